// File: rtl/fifo_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter_if
//
// Bundles the signals between a set of byte producers, the round-robin write
// arbiter and the write side of the shared FIFO.
//
//   master : producer / FIFO side (drives REQ, REQ_DATA, FLUSH, F_FULL_N)
//   slave  : arbiter side (drives ACK, WRITE, DATA_IN, CLEAR_N, BUSY, STALL,
//            GNT_ID)
//
// Signals:
//   REQ       [NREQ]      per-requester write request, level-sensitive
//   REQ_DATA  [NREQ*DW]   requester i data at [i*DW +: DW]
//   FLUSH     [1]         flush command, honoured only while idle
//   F_FULL_N  [1]         FIFO not-full flag
//   ACK       [NREQ]      one-hot, one-cycle acknowledge
//   WRITE     [1]         FIFO write strobe
//   DATA_IN   [DW]        FIFO write data
//   CLEAR_N   [1]         FIFO synchronous clear, active-low
//   BUSY      [1]         arbiter not idle
//   STALL     [1]         a request is pending while the FIFO is full
//   GNT_ID    [3]         index of the last granted requester
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface fifo_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    REQ;
    logic [NREQ*DW-1:0] REQ_DATA;
    logic               FLUSH;
    logic               F_FULL_N;
    logic [NREQ-1:0]    ACK;
    logic               WRITE;
    logic [DW-1:0]      DATA_IN;
    logic               CLEAR_N;
    logic               BUSY;
    logic               STALL;
    logic [2:0]         GNT_ID;

    modport master (
        output REQ, REQ_DATA, FLUSH, F_FULL_N,
        input  ACK, WRITE, DATA_IN, CLEAR_N, BUSY, STALL, GNT_ID
    );

    modport slave (
        input  REQ, REQ_DATA, FLUSH, F_FULL_N,
        output ACK, WRITE, DATA_IN, CLEAR_N, BUSY, STALL, GNT_ID
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter sharing the write port of a FIFO between NREQ producers.
// From IDLE it either starts a one-cycle FLUSH (clear pulse, takes priority)
// or grants the round-robin winner for a one-cycle WR (write + ack). No grant
// is made while the FIFO reports full. Every transaction returns to IDLE, so
// the FIFO's registered full flag is always fresh when the next grant is made.
//
// Ports:
//   CLOCK    in  system clock, rising edge
//   RESET_N  in  asynchronous active-low reset
//   bus      slave modport of fifo_write_arbiter_if (requests, data, flush,
//            FIFO full flag in; ack, write, data, clear, status out)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fifo_write_arbiter #(
    parameter int NREQ = 4,   // 2..8
    parameter int DW   = 8
) (
    input  logic                 CLOCK,
    input  logic                 RESET_N,
    fifo_write_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_FLUSH
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] prio;       // first index searched by the round-robin scan
    logic       win_found;
    logic [2:0] win_idx;
    logic       grant;
    logic       flush_go;

    // Round-robin winner: scan offsets 0..NREQ-1 from prio, first asserted
    // request wins. The inner loop maps each offset onto a constant index so
    // REQ is only ever indexed by loop constants.
    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!win_found && bus.REQ[i] && (i == ((int'(prio) + k) % NREQ))) begin
                    win_found = 1'b1;
                    win_idx   = 3'(i);
                end
            end
        end
    end

    // Next state. Flush outranks a pending request; WR and FLUSH each last
    // exactly one cycle.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        flush_go  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.FLUSH) begin
                    state_nxt = S_FLUSH;
                    flush_go  = 1'b1;
                end else if (win_found && bus.F_FULL_N) begin
                    state_nxt = S_WR;
                    grant     = 1'b1;
                end
            end
            S_WR:    state_nxt = S_IDLE;
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, pointer and registered FIFO-side outputs. WRITE/ACK/CLEAR_N are
    // driven straight from the transition decision so they are high exactly
    // during the WR/FLUSH cycle; DATA_IN and GNT_ID hold until the next grant.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            prio        <= '0;
            bus.WRITE   <= 1'b0;
            bus.ACK     <= '0;
            bus.CLEAR_N <= 1'b1;
            bus.DATA_IN <= '0;
            bus.GNT_ID  <= '0;
        end else begin
            state       <= state_nxt;
            bus.WRITE   <= grant;
            bus.ACK     <= grant ? (NREQ'(1) << win_idx) : '0;
            bus.CLEAR_N <= !flush_go;
            if (grant) begin
                bus.DATA_IN <= bus.REQ_DATA[win_idx*DW +: DW];
                bus.GNT_ID  <= win_idx;
                prio        <= (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
            end
        end
    end

    assign bus.BUSY  = (state != S_IDLE);
    assign bus.STALL = (state == S_IDLE) && (|bus.REQ) && !bus.F_FULL_N;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Bench for fifo_write_arbiter with NREQ=4, DW=8. A small behavioural 32-deep
// FIFO model sits on the write side and supplies a registered F_FULL_N.
// Table-driven vectors cover the single-requester and round-robin sequences;
// hand-written sequences cover reset, full/stall, withdrawn request and
// flush-versus-request.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fifo_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    fifo_write_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    // ---------------- FIFO model (32 x 8, synchronous clear) ----------------
    logic [7:0] fifo_q[$];
    logic [5:0] use_dw;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       overflow;

    assign bus.F_FULL_N = (use_dw != 6'd32);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
            use_dw   <= '0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else if (!bus.CLEAR_N) begin
            fifo_q.delete();
            use_dw <= '0;
        end else begin
            if (rd_en && fifo_q.size() > 0)
                rd_data <= fifo_q.pop_front();
            if (bus.WRITE) begin
                if (fifo_q.size() >= 32)
                    overflow <= 1'b1;
                else
                    fifo_q.push_back(bus.DATA_IN);
            end
            use_dw <= 6'(fifo_q.size());
        end
    end

    // ---------------- checking ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  req;
        logic        flush;
        logic [31:0] data;
        logic        write;
        logic [3:0]  ack;
        logic        clear_n;
        logic [2:0]  gnt;
        logic [7:0]  din;
        logic        busy;
        logic        stall;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] req, input logic [31:0] data,
                                input logic write, input logic [3:0] ack,
                                input logic [2:0] gnt, input logic [7:0] din,
                                input logic busy);
        vec_t v;
        v.req     = req;
        v.flush   = 1'b0;
        v.data    = data;
        v.write   = write;
        v.ack     = ack;
        v.clear_n = 1'b1;
        v.gnt     = gnt;
        v.din     = din;
        v.busy    = busy;
        v.stall   = 1'b0;
        return v;
    endfunction

    // Called at a falling edge: drive, let one rising edge pass, compare.
    task automatic apply_vec(input vec_t v, input string tag);
        bus.REQ      = v.req;
        bus.FLUSH    = v.flush;
        bus.REQ_DATA = v.data;
        @(negedge clk);
        check({tag, " WRITE"},   32'(bus.WRITE),   32'(v.write));
        check({tag, " ACK"},     32'(bus.ACK),     32'(v.ack));
        check({tag, " CLEAR_N"}, 32'(bus.CLEAR_N), 32'(v.clear_n));
        check({tag, " GNT_ID"},  32'(bus.GNT_ID),  32'(v.gnt));
        check({tag, " DATA_IN"}, 32'(bus.DATA_IN), 32'(v.din));
        check({tag, " BUSY"},    32'(bus.BUSY),    32'(v.busy));
        check({tag, " STALL"},   32'(bus.STALL),   32'(v.stall));
    endtask

    task automatic fifo_read(input string tag, input logic [7:0] exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, " rd_data"}, 32'(rd_data), 32'(exp));
    endtask

    localparam logic [31:0] DATA_A = {8'h00, 8'd37, 8'h00, 8'h00};
    localparam logic [31:0] DATA_B = 32'hA3A2A1A0;

    vec_t vec_a[3];
    vec_t vec_b[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  got;
        int  wr_seen;
        int  stall_bad;
        logic [7:0] exp_rr[6];

        // Single requester from reset (prio = 0).
        vec_a[0] = mk(4'b0000, DATA_A, 1'b0, 4'b0000, 3'd0, 8'h00, 1'b0);
        vec_a[1] = mk(4'b0100, DATA_A, 1'b1, 4'b0100, 3'd2, 8'd37, 1'b1);
        vec_a[2] = mk(4'b0000, DATA_A, 1'b0, 4'b0000, 3'd2, 8'd37, 1'b0);
        // Round robin from prio 0, all requests high; REQ drops at the end of
        // the last ACK cycle.
        vec_b[0]  = mk(4'b1111, DATA_B, 1'b1, 4'b0001, 3'd0, 8'hA0, 1'b1);
        vec_b[1]  = mk(4'b1111, DATA_B, 1'b0, 4'b0000, 3'd0, 8'hA0, 1'b0);
        vec_b[2]  = mk(4'b1111, DATA_B, 1'b1, 4'b0010, 3'd1, 8'hA1, 1'b1);
        vec_b[3]  = mk(4'b1111, DATA_B, 1'b0, 4'b0000, 3'd1, 8'hA1, 1'b0);
        vec_b[4]  = mk(4'b1111, DATA_B, 1'b1, 4'b0100, 3'd2, 8'hA2, 1'b1);
        vec_b[5]  = mk(4'b1111, DATA_B, 1'b0, 4'b0000, 3'd2, 8'hA2, 1'b0);
        vec_b[6]  = mk(4'b1111, DATA_B, 1'b1, 4'b1000, 3'd3, 8'hA3, 1'b1);
        vec_b[7]  = mk(4'b1111, DATA_B, 1'b0, 4'b0000, 3'd3, 8'hA3, 1'b0);
        vec_b[8]  = mk(4'b1111, DATA_B, 1'b1, 4'b0001, 3'd0, 8'hA0, 1'b1);
        vec_b[9]  = mk(4'b1111, DATA_B, 1'b0, 4'b0000, 3'd0, 8'hA0, 1'b0);
        vec_b[10] = mk(4'b1111, DATA_B, 1'b1, 4'b0010, 3'd1, 8'hA1, 1'b1);
        vec_b[11] = mk(4'b0000, DATA_B, 1'b0, 4'b0000, 3'd1, 8'hA1, 1'b0);
        exp_rr = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};

        bus.REQ      = '0;
        bus.REQ_DATA = '0;
        bus.FLUSH    = 1'b0;
        rd_en        = 1'b0;

        // ---- reset state ----
        #12;
        check("rst WRITE",   32'(bus.WRITE),   32'd0);
        check("rst ACK",     32'(bus.ACK),     32'd0);
        check("rst CLEAR_N", 32'(bus.CLEAR_N), 32'd1);
        check("rst DATA_IN", 32'(bus.DATA_IN), 32'd0);
        check("rst GNT_ID",  32'(bus.GNT_ID),  32'd0);
        check("rst BUSY",    32'(bus.BUSY),    32'd0);
        check("rst STALL",   32'(bus.STALL),   32'd0);
        check("rst USE_DW",  32'(use_dw),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- single requester ----
        for (int i = 0; i < 3; i++) apply_vec(vec_a[i], $sformatf("single[%0d]", i));
        check("single USE_DW", 32'(use_dw), 32'd1);
        fifo_read("single", 8'd37);
        check("single USE_DW after read", 32'(use_dw), 32'd0);

        // ---- reset in the middle of a WR cycle ----
        bus.REQ      = 4'b0001;
        bus.REQ_DATA = DATA_B;
        @(posedge clk);
        #2;
        check("midrst WRITE before", 32'(bus.WRITE), 32'd1);
        rst_n   = 1'b0;
        bus.REQ = '0;
        #1;
        check("midrst WRITE",   32'(bus.WRITE),   32'd0);
        check("midrst ACK",     32'(bus.ACK),     32'd0);
        check("midrst CLEAR_N", 32'(bus.CLEAR_N), 32'd1);
        check("midrst DATA_IN", 32'(bus.DATA_IN), 32'd0);
        check("midrst GNT_ID",  32'(bus.GNT_ID),  32'd0);
        check("midrst BUSY",    32'(bus.BUSY),    32'd0);
        check("midrst STALL",   32'(bus.STALL),   32'd0);
        check("midrst USE_DW",  32'(use_dw),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- round robin ----
        for (int i = 0; i < 12; i++) apply_vec(vec_b[i], $sformatf("rr[%0d]", i));
        check("rr USE_DW", 32'(use_dw), 32'd6);
        for (int i = 0; i < 6; i++) fifo_read($sformatf("rr read%0d", i), exp_rr[i]);
        check("rr USE_DW drained", 32'(use_dw), 32'd0);

        // ---- fill to 32 through REQ[0], then stall REQ[1] ----
        bus.REQ      = 4'b0001;
        bus.REQ_DATA = DATA_B;
        got = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (use_dw == 6'd32) begin
                got = 1;
                break;
            end
        end
        check("full reached 32", 32'(got), 32'd1);
        bus.REQ   = 4'b0010;
        wr_seen   = 0;
        stall_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.WRITE !== 1'b0) wr_seen++;
            if (bus.STALL !== 1'b1) stall_bad++;
        end
        check("full F_FULL_N",     32'(bus.F_FULL_N), 32'd0);
        check("full writes seen",  32'(wr_seen),      32'd0);
        check("full STALL misses", 32'(stall_bad),    32'd0);
        check("full USE_DW",       32'(use_dw),       32'd32);

        fifo_read("full", 8'hA0);
        check("full USE_DW after read", 32'(use_dw),    32'd31);
        check("full STALL after read",  32'(bus.STALL), 32'd0);
        got = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (bus.ACK[1]) begin
                got = 1;
                break;
            end
        end
        check("full ACK[1] seen", 32'(got),         32'd1);
        check("full GNT_ID",      32'(bus.GNT_ID),  32'd1);
        check("full DATA_IN",     32'(bus.DATA_IN), 32'hA1);
        check("full STALL in WR", 32'(bus.STALL),   32'd0);
        bus.REQ = '0;
        @(negedge clk);
        check("full USE_DW refilled", 32'(use_dw), 32'd32);

        // ---- withdrawn request while full; prio must stay at 2 ----
        bus.REQ = 4'b0010;
        @(negedge clk);
        check("withdraw ACK",   32'(bus.ACK),   32'd0);
        check("withdraw WRITE", 32'(bus.WRITE), 32'd0);
        check("withdraw STALL", 32'(bus.STALL), 32'd1);
        bus.REQ = '0;
        rd_en   = 1'b1;
        @(negedge clk);
        rd_en   = 1'b0;
        bus.REQ = 4'b1111;
        @(negedge clk);
        check("withdraw next ACK",     32'(bus.ACK),     32'b0100);
        check("withdraw next GNT_ID",  32'(bus.GNT_ID),  32'd2);
        check("withdraw next DATA_IN", 32'(bus.DATA_IN), 32'hA2);
        bus.REQ = '0;
        @(negedge clk);
        check("withdraw USE_DW", 32'(use_dw), 32'd32);

        // ---- flush and request on the same edge ----
        bus.FLUSH = 1'b1;
        bus.REQ   = 4'b1000;
        @(negedge clk);
        check("flush CLEAR_N low", 32'(bus.CLEAR_N), 32'd0);
        check("flush ACK",         32'(bus.ACK),     32'd0);
        check("flush WRITE",       32'(bus.WRITE),   32'd0);
        check("flush BUSY",        32'(bus.BUSY),    32'd1);
        bus.FLUSH = 1'b0;
        @(negedge clk);
        check("flush CLEAR_N back", 32'(bus.CLEAR_N), 32'd1);
        check("flush ACK after",    32'(bus.ACK),     32'd0);
        check("flush USE_DW empty", 32'(use_dw),      32'd0);
        check("flush BUSY after",   32'(bus.BUSY),    32'd0);
        @(negedge clk);
        check("flush then ACK[3]",   32'(bus.ACK),     32'b1000);
        check("flush then GNT_ID",   32'(bus.GNT_ID),  32'd3);
        check("flush then DATA_IN",  32'(bus.DATA_IN), 32'hA3);
        bus.REQ = '0;
        @(negedge clk);
        check("flush then USE_DW", 32'(use_dw), 32'd1);
        fifo_read("flush", 8'hA3);

        check("no overflow write", 32'(overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
